ysyx_25040105_imem_responder: RTL and testbench
===============================================

// Module: ysyx_25040105_imem_responder
// PURPOSE
//   Instruction-memory responder serving the core's fetch side: accepts a PC
//   request, waits a fixed access latency, returns the 32-bit instruction word.
//   Sits between the IFU PC output and the decoder's instruction input and
//   replaces the testbench-driven inst bus with a handshaked, latency-modelled
//   memory. A word-wide preload port fills the array before or during a run.
// PARAMETERS
//   BASE_ADDR  32'h8000_0000  byte address of word 0
//   DEPTH      4096           number of 32-bit words (power of 2, >=2)
//   LATENCY    2              wait cycles between request accept and response (0..15)
// PORTS
//   clk        in   1   clock; all state changes on posedge
//   rst        in   1   asynchronous, active-low reset
//   req_valid  in   1   fetch request present
//   req_ready  out  1   responder can accept a request
//   req_addr   in   32  fetch byte address (PC)
//   resp_valid out  1   response word valid
//   resp_ready in   1   consumer accepts response
//   resp_inst  out  32  instruction word
//   resp_err   out  1   misaligned or out-of-range request
//   flush      in   1   discard in-flight request/response (taken jump)
//   ld_en      in   1   preload write enable
//   ld_idx     in   log2(DEPTH)  preload word index
//   ld_data    in   32  preload word
// BEHAVIOUR
//   - Reset (rst=0, async): state=IDLE, wait counter=0, req_ready=1,
//     resp_valid=0, resp_inst=0, resp_err=0. Memory contents undefined/unchanged.
//   - FSM: IDLE -> WAIT -> RESP -> IDLE.
//     IDLE: req_ready=1. On req_valid&&!flush: latch addr, counter=LATENCY;
//       go to WAIT (LATENCY>0) or RESP (LATENCY=0).
//     WAIT: req_ready=0, counter decrements each cycle; when counter==1 the
//       next state is RESP.
//     RESP: resp_valid=1; resp_inst/resp_err stable until resp_ready=1, then IDLE.
//   - Latency: request accepted at edge t -> resp_valid high from t+1+LATENCY.
//     No overlap: one transaction in flight, req_ready=0 outside IDLE.
//   - Data capture: the memory word is read on the cycle of the transition into
//     RESP and registered into resp_inst.
//   - Address check: off = req_addr - BASE_ADDR (32-bit, wraps).
//     err if req_addr[1:0]!=0 or off[31:2] >= DEPTH. Addresses below BASE_ADDR
//     wrap to a huge offset and are therefore errors. On err: resp_err=1,
//     resp_inst=0. Otherwise resp_err=0, resp_inst=mem[off[31:2]].
//   - Preload: ld_en writes mem[ld_idx]=ld_data at the posedge, in any state.
//     A write to the word being captured in the same cycle returns OLD data.
//   - flush: highest priority after reset. In WAIT or RESP -> IDLE next cycle,
//     resp_valid=0, and no response is ever delivered for that request. In IDLE,
//     a coincident req_valid is not accepted.
//   - resp_ready is ignored outside RESP. req_addr is ignored outside IDLE.
//   - Reset mid-transaction aborts it; no stale response after release.
// TESTING
//   1. Preload mem[0]=32'h00100073, LATENCY=2, req 0x8000_0000 at t -> resp_valid
//      at t+3, resp_inst=32'h00100073, resp_err=0.
//   2. Hold resp_ready=0 for 5 cycles in RESP -> resp_valid and resp_inst stay
//      stable; req_ready=0 throughout; IDLE one cycle after resp_ready=1.
//   3. req 0x8000_0002 -> resp_err=1, resp_inst=0. req 0x7FFF_FFFC -> err=1.
//      req BASE+4*DEPTH -> err=1.
//   4. flush one cycle after accept -> no resp_valid; next req 0x8000_0004
//      returns mem[1].
//   5. ld_en to mem[1] on the capture cycle of a req to 0x8000_0004 -> old
//      value returned; a repeat request returns the new value.
//   6. Assert rst=0 asynchronously in WAIT -> outputs at reset values immediately;
//      no response after release. LATENCY=0 variant: response at t+1.

Source files
------------

// File: rtl/ysyx_25040105_imem_responder.sv
// -----------------------------------------------------------------------------
// ysyx_25040105_imem_responder
//
// Instruction-memory responder for the fetch side of the core. It accepts one
// PC request at a time, waits a fixed LATENCY, then presents the 32-bit
// instruction word (or an error flag) until the consumer takes it. A word-wide
// preload port can fill the array at any time, including mid-transaction.
//
// Ports
//   clk        clock, all state changes on posedge
//   rst        asynchronous, active-low reset
//   req_valid  fetch request present
//   req_ready  high in IDLE only: a request can be accepted
//   req_addr   fetch byte address (PC), sampled only on accept
//   resp_valid response word valid (RESP state)
//   resp_ready consumer accepts the response
//   resp_inst  instruction word, 0 on error
//   resp_err   misaligned or out-of-range request
//   flush      discard any in-flight request/response (taken jump)
//   ld_en      preload write enable
//   ld_idx     preload word index
//   ld_data    preload word
// -----------------------------------------------------------------------------
module ysyx_25040105_imem_responder #(
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int unsigned DEPTH     = 4096,
    parameter int unsigned LATENCY   = 2,
    localparam int unsigned IDX_W    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_addr,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [31:0]      resp_inst,
    output logic             resp_err,
    input  logic             flush,
    input  logic             ld_en,
    input  logic [IDX_W-1:0] ld_idx,
    input  logic [31:0]      ld_data
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    localparam logic [3:0] LAT4 = 4'(LATENCY);

    // Word offset of req_addr from BASE_ADDR. For an aligned request this is
    // exactly (req_addr - BASE_ADDR) >> 2; an unaligned BASE_ADDR contributes a
    // borrow out of the low two bits, folded into BASE_WORD. Misaligned requests
    // are errors regardless of the offset, so the low bits are never needed.
    localparam logic [29:0] BASE_WORD = BASE_ADDR[31:2] + 30'(BASE_ADDR[1:0] != 2'b00);

    logic [31:0]      mem [DEPTH];

    state_t           state;
    state_t           state_next;
    logic [3:0]       wait_cnt;
    logic [IDX_W-1:0] lat_idx;
    logic             lat_err;

    logic [29:0]      off_word;
    logic [IDX_W-1:0] req_idx;
    logic             req_err;
    logic [IDX_W-1:0] cap_idx;
    logic             cap_err;
    logic             accept;
    logic             entering_resp;

    // ---------------------------------------------------------------- decode
    assign off_word = req_addr[31:2] - BASE_WORD;
    assign req_idx  = off_word[IDX_W-1:0];
    // Addresses below BASE_ADDR wrap to a huge offset and fail the range test.
    assign req_err  = (req_addr[1:0] != 2'b00) || ({2'b00, off_word} >= 32'(DEPTH));

    assign accept        = (state == ST_IDLE) && req_valid && !flush;
    assign entering_resp = (state_next == ST_RESP) && (state != ST_RESP);

    // With LATENCY=0 the capture happens on the accept edge itself, so the
    // live request decode is used instead of the latched copy.
    assign cap_idx = (state == ST_IDLE) ? req_idx : lat_idx;
    assign cap_err = (state == ST_IDLE) ? req_err : lat_err;

    // ---------------------------------------------------------- state register
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values; blocking here would make results depend on block order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------ next state
    // NOTE: every variable assigned in a combinational block gets a default at
    // the top; a path that leaves one unassigned would infer a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_next = (LATENCY == 0) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (flush) begin
                    state_next = ST_IDLE;
                end else if (wait_cnt == 4'd1) begin
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                if (flush || resp_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // --------------------------------------------------------------- outputs
    always_comb begin
        req_ready  = (state == ST_IDLE);
        resp_valid = (state == ST_RESP);
    end

    // ------------------------------------------------ counter and request latch
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt <= 4'd0;
            lat_idx  <= '0;
            lat_err  <= 1'b0;
        end else if (accept) begin
            wait_cnt <= LAT4;
            lat_idx  <= req_idx;
            lat_err  <= req_err;
        end else if (state == ST_WAIT) begin
            wait_cnt <= wait_cnt - 4'd1;
        end
    end

    // --------------------------------------------------------- response data
    // The array is read on the edge that enters RESP; a preload to the same
    // word on that edge lands after the read, so the old word is returned.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            resp_inst <= 32'd0;
            resp_err  <= 1'b0;
        end else if (entering_resp) begin
            resp_err  <= cap_err;
            resp_inst <= cap_err ? 32'd0 : mem[cap_idx];
        end
    end

    // ---------------------------------------------------------------- memory
    // NOTE: the array has no reset; its contents survive rst and are defined
    // only by preload, which also keeps it mappable onto RAM.
    always_ff @(posedge clk) begin
        if (ld_en) begin
            mem[ld_idx] <= ld_data;
        end
    end

endmodule

// File: tb/tb_ysyx_25040105_imem_responder.sv
// -----------------------------------------------------------------------------
// Directed self-checking bench for ysyx_25040105_imem_responder.
// dut  : default parameters (LATENCY=2, DEPTH=4096)
// dut0 : LATENCY=0, DEPTH=16
// Inputs change 1 time unit after a posedge; outputs are checked there too.
// -----------------------------------------------------------------------------
module tb_ysyx_25040105_imem_responder;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = 32'd0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_inst;
    logic        resp_err;
    logic        flush = 1'b0;
    logic        ld_en = 1'b0;
    logic [11:0] ld_idx = 12'd0;
    logic [31:0] ld_data = 32'd0;

    logic        req_valid0 = 1'b0;
    logic        req_ready0;
    logic [31:0] req_addr0 = 32'd0;
    logic        resp_valid0;
    logic        resp_ready0 = 1'b0;
    logic [31:0] resp_inst0;
    logic        resp_err0;
    logic        ld_en0 = 1'b0;
    logic [3:0]  ld_idx0 = 4'd0;
    logic [31:0] ld_data0 = 32'd0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ysyx_25040105_imem_responder dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_inst  (resp_inst),
        .resp_err   (resp_err),
        .flush      (flush),
        .ld_en      (ld_en),
        .ld_idx     (ld_idx),
        .ld_data    (ld_data)
    );

    ysyx_25040105_imem_responder #(
        .DEPTH   (16),
        .LATENCY (0)
    ) dut0 (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid0),
        .req_ready  (req_ready0),
        .req_addr   (req_addr0),
        .resp_valid (resp_valid0),
        .resp_ready (resp_ready0),
        .resp_inst  (resp_inst0),
        .resp_err   (resp_err0),
        .flush      (1'b0),
        .ld_en      (ld_en0),
        .ld_idx     (ld_idx0),
        .ld_data    (ld_data0)
    );

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [11:0] idx, input logic [31:0] data);
        ld_en   = 1'b1;
        ld_idx  = idx;
        ld_data = data;
        tick();
        ld_en   = 1'b0;
    endtask

    // One full transaction on dut with exact latency checking, then consume.
    task automatic fetch(input string tag, input logic [31:0] addr,
                         input logic [31:0] exp_inst, input logic exp_err);
        req_valid = 1'b1;
        req_addr  = addr;
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < LAT; i++) begin
            check1({tag, "_wait_valid"}, resp_valid, 1'b0);
            tick();
        end
        check1 ({tag, "_valid"}, resp_valid, 1'b1);
        check32({tag, "_inst"},  resp_inst,  exp_inst);
        check1 ({tag, "_err"},   resp_err,   exp_err);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check1({tag, "_back_idle"}, req_ready, 1'b1);
    endtask

    initial begin
        // ---------------------------------------------------------- reset
        tick();
        tick();
        check1 ("rst_req_ready",  req_ready,  1'b1);
        check1 ("rst_resp_valid", resp_valid, 1'b0);
        check32("rst_resp_inst",  resp_inst,  32'd0);
        check1 ("rst_resp_err",   resp_err,   1'b0);
        rst = 1'b1;
        tick();

        load(12'd0,    32'h0010_0073);
        load(12'd1,    32'hDEAD_BEEF);
        load(12'd4095, 32'hCAFE_F00D);

        // ---------------------------------- 1+2: basic fetch with backpressure
        req_valid = 1'b1;
        req_addr  = 32'h8000_0000;
        tick();
        req_valid = 1'b0;
        req_addr  = 32'h8000_0004;   // ignored outside IDLE
        check1("t1_ready_low",  req_ready,  1'b0);
        check1("t1_valid_t1",   resp_valid, 1'b0);
        tick();
        check1("t1_valid_t2",   resp_valid, 1'b0);
        tick();
        check1 ("t1_valid_t3",  resp_valid, 1'b1);
        check32("t1_inst",      resp_inst,  32'h0010_0073);
        check1 ("t1_err",       resp_err,   1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check1 ("t2_hold_valid", resp_valid, 1'b1);
            check32("t2_hold_inst",  resp_inst,  32'h0010_0073);
            check1 ("t2_hold_ready", req_ready,  1'b0);
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check1("t2_done_valid", resp_valid, 1'b0);
        check1("t2_done_ready", req_ready,  1'b1);

        // ----------------------------------------------- 3: address checks
        fetch("t3_misalign", 32'h8000_0002, 32'd0,         1'b1);
        fetch("t3_below",    32'h7FFF_FFFC, 32'd0,         1'b1);
        fetch("t3_above",    32'h8000_4000, 32'd0,         1'b1);
        fetch("t3_last",     32'h8000_3FFC, 32'hCAFE_F00D, 1'b0);

        // ----------------------------------------------------- 4: flush
        req_valid = 1'b1;
        req_addr  = 32'h8000_0000;
        tick();
        req_valid = 1'b0;
        flush     = 1'b1;
        tick();
        flush     = 1'b0;
        check1("t4_flush_idle", req_ready, 1'b1);
        for (int i = 0; i < 3; i++) begin
            check1("t4_no_resp", resp_valid, 1'b0);
            tick();
        end
        // flush coincident with a request in IDLE blocks the accept
        flush     = 1'b1;
        req_valid = 1'b1;
        tick();
        flush     = 1'b0;
        req_valid = 1'b0;
        check1("t4_idle_flush_ready", req_ready, 1'b1);
        tick();
        check1("t4_idle_flush_valid", resp_valid, 1'b0);
        // flush while the response is being held
        req_valid = 1'b1;
        req_addr  = 32'h8000_0000;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        check1("t4_resp_before_flush", resp_valid, 1'b1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check1("t4_resp_flushed", resp_valid, 1'b0);
        check1("t4_resp_flushed_ready", req_ready, 1'b1);
        fetch("t4_after", 32'h8000_0004, 32'hDEAD_BEEF, 1'b0);

        // ------------------------------ 5: preload on the capture cycle
        req_valid = 1'b1;
        req_addr  = 32'h8000_0004;
        tick();
        req_valid = 1'b0;
        tick();
        ld_en   = 1'b1;
        ld_idx  = 12'd1;
        ld_data = 32'h1234_5678;
        tick();
        ld_en   = 1'b0;
        check1 ("t5_valid",    resp_valid, 1'b1);
        check32("t5_old_data", resp_inst,  32'hDEAD_BEEF);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        fetch("t5_new", 32'h8000_0004, 32'h1234_5678, 1'b0);

        // ---------------------------------- 6: async reset mid-WAIT
        req_valid = 1'b1;
        req_addr  = 32'h8000_0000;
        tick();
        req_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check1 ("t6_rst_ready", req_ready,  1'b1);
        check1 ("t6_rst_valid", resp_valid, 1'b0);
        check32("t6_rst_inst",  resp_inst,  32'd0);
        check1 ("t6_rst_err",   resp_err,   1'b0);
        tick();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check1("t6_no_stale", resp_valid, 1'b0);
        end
        fetch("t6_mem_kept", 32'h8000_0000, 32'h0010_0073, 1'b0);

        // ------------------------------------------- 6b: LATENCY=0 instance
        ld_en0   = 1'b1;
        ld_idx0  = 4'd2;
        ld_data0 = 32'hAABB_CCDD;
        tick();
        ld_idx0  = 4'd15;
        ld_data0 = 32'h0BAD_F00D;
        tick();
        ld_en0   = 1'b0;
        req_valid0 = 1'b1;
        req_addr0  = 32'h8000_0008;
        tick();
        req_valid0 = 1'b0;
        check1 ("l0_valid", resp_valid0, 1'b1);
        check32("l0_inst",  resp_inst0,  32'hAABB_CCDD);
        check1 ("l0_err",   resp_err0,   1'b0);
        check1 ("l0_ready", req_ready0,  1'b0);
        resp_ready0 = 1'b1;
        tick();
        resp_ready0 = 1'b0;
        check1("l0_idle", resp_valid0, 1'b0);
        req_valid0 = 1'b1;
        req_addr0  = 32'h8000_003C;
        tick();
        req_valid0 = 1'b0;
        check32("l0_last_inst", resp_inst0, 32'h0BAD_F00D);
        check1 ("l0_last_err",  resp_err0,  1'b0);
        resp_ready0 = 1'b1;
        tick();
        resp_ready0 = 1'b0;
        req_valid0 = 1'b1;
        req_addr0  = 32'h8000_0040;
        tick();
        req_valid0 = 1'b0;
        check1 ("l0_oor_valid", resp_valid0, 1'b1);
        check1 ("l0_oor_err",   resp_err0,   1'b1);
        check32("l0_oor_inst",  resp_inst0,  32'd0);
        resp_ready0 = 1'b1;
        tick();
        resp_ready0 = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
